// File: rtl/mw_writeback_stage.sv
// Memory/writeback pipeline latch and register-file write port driver.
// Optional retire counter is built when MW_RETIRE_COUNT_EN is defined.
module mw_writeback_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] o_in,
  input  logic [31:0] d_in,
  input  logic [31:0] pc1_in,
  input  logic [4:0]  rd_in,
  input  logic [1:0]  sel_in,
  input  logic        we_in,
  input  logic        ovf_in,
  input  logic [2:0]  exc_in,
  input  logic        stall,
  input  logic        flush,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_ctrl,
  output logic [31:0] rf_write_data,
  output logic        bypass_valid,
  output logic [31:0] retired_count
);

  localparam int unsigned DataW = 32;
  localparam int unsigned RegW  = 5;
  localparam int unsigned ExcW  = 3;
  localparam logic [RegW-1:0] StatusReg = RegW'(30);

  logic             valid_q, valid_d;
  logic [DataW-1:0] o_q, o_d;
  logic [DataW-1:0] d_q, d_d;
  logic [DataW-1:0] pc1_q, pc1_d;
  logic [RegW-1:0]  rd_q, rd_d;
  logic [1:0]       sel_q, sel_d;
  logic             we_q, we_d;
  logic             ovf_q, ovf_d;
  logic [ExcW-1:0]  exc_q, exc_d;

  // Latch next state: flush kills the valid bit and wins over stall; stall holds.
  always_comb begin
    valid_d = valid_q;
    o_d     = o_q;
    d_d     = d_q;
    pc1_d   = pc1_q;
    rd_d    = rd_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ovf_d   = ovf_q;
    exc_d   = exc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = valid_in;
      o_d     = o_in;
      d_d     = d_in;
      pc1_d   = pc1_in;
      rd_d    = rd_in;
      sel_d   = sel_in;
      we_d    = we_in;
      ovf_d   = ovf_in;
      exc_d   = exc_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      o_q     <= '0;
      d_q     <= '0;
      pc1_q   <= '0;
      rd_q    <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
      exc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      o_q     <= o_d;
      d_q     <= d_d;
      pc1_q   <= pc1_d;
      rd_q    <= rd_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
      exc_q   <= exc_d;
    end
  end

  logic             ovf_take;
  logic [DataW-1:0] sel_data;

  // An overflowing instruction is redirected to the status register with its code.
  always_comb begin
    ovf_take = valid_q & ovf_q;
    sel_data = '0;
    case (sel_q)
      2'b00:   sel_data = o_q;
      2'b01:   sel_data = d_q;
      2'b10:   sel_data = pc1_q;
      default: sel_data = '0;
    endcase
    if (ovf_take) begin
      rf_write_ctrl   = StatusReg;
      rf_write_data   = DataW'(exc_q);
      rf_write_enable = 1'b1;
    end else begin
      rf_write_ctrl   = rd_q;
      rf_write_data   = sel_data;
      rf_write_enable = valid_q & we_q & (rd_q != '0);
    end
  end

  assign bypass_valid = rf_write_enable;

`ifdef MW_RETIRE_COUNT_EN
  logic [DataW-1:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (!stall && !flush && valid_in) begin
      retired_d = retired_q + DataW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: doc/mw_writeback_stage.md
MW_WRITEBACK_STAGE -- requirements
Module: mw_writeback_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-low; sampled on rising clock.
REQ-004 valid_in  in  1  memory stage presents a live instruction.
REQ-005 o_in  in  32  memory-stage ALU/address result.
REQ-006 d_in  in  32  q_dmem read data for loads.
REQ-007 pc1_in  in  32  PC+1 of the instruction, used for jal.
REQ-008 rd_in  in  5  destination register.
REQ-009 sel_in  in  2  writeback source: 00 o_in, 01 d_in, 10 pc1_in, 11 reserved.
REQ-010 we_in  in  1  instruction writes the register file.
REQ-011 ovf_in  in  1  arithmetic overflow flagged upstream.
REQ-012 exc_in  in  3  rstatus code for overflow: add=1, addi=2, sub=3, mul=4, div=5.
REQ-013 stall  in  1  hold the latch contents.
REQ-014 flush  in  1  kill the incoming instruction.
REQ-015 rf_write_enable  out  1  register file write strobe.
REQ-016 rf_write_ctrl  out  5  register file write address.
REQ-017 rf_write_data  out  32  register file write data.
REQ-018 bypass_valid  out  1  the held instruction will write a register (for forwarding).
REQ-019 retired_count  out  32  count of retired instructions (see Configuration).

Function
REQ-020 The M/W latch SHALL capture all *_in signals on a rising edge when stall=0; when stall=1 it SHALL hold.
REQ-021 When flush=1 the latched valid bit SHALL be cleared on the edge; flush SHALL override stall.
REQ-022 Latency SHALL be one cycle: inputs captured at edge N appear on rf_write_* after edge N, combinationally from the latch.
REQ-023 rf_write_enable SHALL equal valid & we & (write address != 0).
REQ-024 With no overflow: rf_write_ctrl = latched rd; rf_write_data selects on sel (00 o, 01 d, 10 pc1, 11 zero).
REQ-025 With latched ovf=1 and valid=1: rf_write_ctrl = 30, rf_write_data = zero-extended exc, and rf_write_enable = 1 regardless of we.
REQ-026 bypass_valid SHALL equal rf_write_enable; forwarding logic uses rf_write_ctrl and rf_write_data.
REQ-027 While stall=1 the outputs SHALL remain constant; the register file tolerates repeated identical writes.
REQ-028 The retire counter SHALL increment by 1 on each edge where the latch loads a valid, unflushed instruction (stall=0, flush=0, valid_in=1). It SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-029 While reset=0 at an edge, the block SHALL clear valid, rd, sel, we, ovf and exc, and clear all data fields to 0.
REQ-030 While reset=0 at an edge, the block SHALL clear retired_count to 0.
REQ-031 Consequently all outputs SHALL be 0 after reset.
REQ-032 Reset SHALL take precedence over stall and flush.
REQ-033 Reset mid-operation SHALL discard the held instruction without a write.

Configuration
REQ-034 Macro MW_RETIRE_COUNT_EN defined: the 32-bit retire counter is built per REQ-028.
REQ-035 MW_RETIRE_COUNT_EN undefined: no counter is built and retired_count is tied to 0.

Verification
REQ-036 Reset, then ALU op rd=7, sel=00, o_in=14, we=1 -> next cycle enable=1, ctrl=7, data=0x0000000E.
REQ-037 Load rd=11, sel=01, d_in=14, o_in=99 -> ctrl=11, data=14; then rd=0, we=1 -> enable=0.
REQ-038 add with ovf_in=1, exc_in=1, rd=5 -> ctrl=30, data=1, enable=1; jal sel=10, pc1_in=0x20, rd=31 -> data=0x20.
REQ-039 Hold stall=1 for 3 cycles while changing inputs -> outputs unchanged; assert flush with stall -> enable=0 next cycle.
REQ-040 With MW_RETIRE_COUNT_EN: 5 valid instructions, 1 flushed and 2 stalled cycles -> retired_count=5; preload 0xFFFFFFFF plus 1 -> 0; macro off -> always 0.
